msk_unshare_stream: RTL and testbench

Output unmasking stage for the masked AES core. It receives the d-share ciphertext as four 32-bit shared words on a valid/ready stream and recombines the shares serially, one share per cycle, so that no cycle combines all shares of a bit combinationally. It buffers the four unmasked words and emits one 128-bit block on a valid/ready stream. It is the decoder counterpart of the input share encoder, and sits between the core's shared output bus and the unmasked host interface.

---
 rtl/msk_unshare_pkg.sv | 22 ++
 rtl/mskshare_sel.sv | 20 ++
 rtl/msk_unshare_stream.sv | 120 ++++++++++++
 tb/tb_msk_unshare_stream.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_unshare_pkg.sv
// Shared definitions for the output unmasking stage: geometry, FSM states and
// the share-index width helper.
package msk_unshare_pkg;

  localparam int unsigned WordW    = 32;
  localparam int unsigned BlkWords = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFold = 2'd1,
    StOut  = 2'd2
  } state_e;

  // Width of a share index for d shares; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned d);
    int unsigned w;
    w = 1;
    if (d > 1) w = $clog2(d);
    return w;
  endfunction

endpackage

// File: rtl/mskshare_sel.sv
// Extracts one 32-bit share from a bit-interleaved shared word
// (share j of bit i sits at index i*D+j). Purely combinational.
module mskshare_sel
  import msk_unshare_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic [WordW*D-1:0]    sh_reg_i,
  input  logic [idx_w(D)-1:0]   idx_i,
  output logic [WordW-1:0]      share_o
);

  // Per bit, slice out the D-wide share group and pick the requested share.
  for (genvar i = 0; i < WordW; i++) begin : g_bit
    logic [D-1:0] grp;
    assign grp        = sh_reg_i[i*D +: D];
    assign share_o[i] = grp[idx_i];
  end

endmodule

// File: rtl/msk_unshare_stream.sv
// Output unmasking stage: captures a d-share word, folds one share per cycle
// into an accumulator, buffers four unmasked words and emits a 128-bit block.
module msk_unshare_stream
  import msk_unshare_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic                   clk,
  input  logic                   syn_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WordW*D-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WordW*BlkWords-1:0] out_data
);

  localparam int unsigned IdxW = idx_w(D);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(D - 1);

  state_e               state_q, state_d;
  logic [WordW*D-1:0]   sh_reg_q, sh_reg_d;
  logic [WordW-1:0]     acc_q, acc_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic [WordW-1:0]     buf_q [BlkWords];
  logic [WordW-1:0]     buf_d [BlkWords];

  logic [WordW-1:0]     in_share0;
  logic [WordW-1:0]     cur_share;
  logic [WordW-1:0]     folded;

  // Share 0 of the incoming word only; no shares are combined at capture.
  for (genvar i = 0; i < WordW; i++) begin : g_share0
    assign in_share0[i] = in_data[i*D];
  end

  // Share selection works off the registered word, never the live input.
  mskshare_sel #(
    .D (D)
  ) u_sel (
    .sh_reg_i (sh_reg_q),
    .idx_i    (idx_q),
    .share_o  (cur_share)
  );

  assign folded = acc_q ^ cur_share;

  // Next-state, handshake outputs and register updates for the unshare FSM.
  always_comb begin
    state_d   = state_q;
    sh_reg_d  = sh_reg_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = syn_rst_n;
        if (in_valid && in_ready) begin
          sh_reg_d = in_data;
          acc_d    = in_share0;
          idx_d    = IdxW'(1);
          state_d  = StFold;
        end
      end
      StFold: begin
        if (idx_q == LastIdx) begin
          buf_d[wcnt_q] = folded;
          // Scrub the shares and partial sum once the word is recombined.
          sh_reg_d      = '0;
          acc_d         = '0;
          idx_d         = '0;
          wcnt_d        = wcnt_q + 2'd1;
          state_d       = (wcnt_q == 2'd3) ? StOut : StIdle;
        end else begin
          acc_d = folded;
          idx_d = idx_q + IdxW'(1);
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          buf_d   = '{default: '0};
          wcnt_d  = 2'd0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Block data is only driven while offered, so partial plaintext never leaks.
  assign out_data = (state_q == StOut) ? {buf_q[0], buf_q[1], buf_q[2], buf_q[3]} : '0;

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      state_q  <= StIdle;
      sh_reg_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      buf_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      sh_reg_q <= sh_reg_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: tb/tb_msk_unshare_stream.sv
// Self-checking bench for msk_unshare_stream with d=2 and d=4 instances.
module tb_msk_unshare_stream;

  logic clk = 1'b0;
  logic rst_n;

  logic         v2, rdy2, ov2, ordy2;
  logic [63:0]  data2;
  logic [127:0] od2;
  logic         v4, rdy4, ov4, ordy4;
  logic [127:0] data4;
  logic [127:0] od4;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] m;
    logic [31:0] r;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vec [8];
  logic [31:0] ref_q [$];

  always #5 clk = ~clk;

  msk_unshare_stream #(.D(2)) dut2 (
    .clk       (clk),
    .syn_rst_n (rst_n),
    .in_valid  (v2),
    .in_ready  (rdy2),
    .in_data   (data2),
    .out_valid (ov2),
    .out_ready (ordy2),
    .out_data  (od2)
  );

  msk_unshare_stream #(.D(4)) dut4 (
    .clk       (clk),
    .syn_rst_n (rst_n),
    .in_valid  (v4),
    .in_ready  (rdy4),
    .in_data   (data4),
    .out_valid (ov4),
    .out_ready (ordy4),
    .out_data  (od4)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack2(input logic [31:0] m, input logic [31:0] r);
    logic [63:0] p;
    for (int i = 0; i < 32; i++) begin
      p[2*i]   = m[i] ^ r[i];
      p[2*i+1] = r[i];
    end
    return p;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] s0, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] s3);
    logic [127:0] p;
    for (int i = 0; i < 32; i++) begin
      p[4*i]   = s0[i];
      p[4*i+1] = s1[i];
      p[4*i+2] = s2[i];
      p[4*i+3] = s3[i];
    end
    return p;
  endfunction

  // Reference block: the four unmasked words in arrival order, word 0 on top.
  function automatic logic [127:0] ref_block();
    return {ref_q[0], ref_q[1], ref_q[2], ref_q[3]};
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send2(input logic [31:0] m, input logic [31:0] r);
    int n;
    n = 0;
    v2 = 1'b1;
    data2 = pack2(m, r);
    @(negedge clk);
    while (!rdy2 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy2) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send2 timeout: in_ready=%0b expected 1", rdy2);
    end
    @(posedge clk); #1;
    v2 = 1'b0;
  endtask

  task automatic expect_blk2(input string name, input logic [127:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!ov2 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({name, " out_valid"}, ov2, 128'(1));
    check(name, od2, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m, r1, r2, r3;
    logic [31:0] mw [4];
    logic [127:0] w4 [4];
    int acc_cyc [4];
    int cyc, k, n;

    vec[0] = '{32'h00112233, 32'hA5A5A5A5, 32'h00112233};
    vec[1] = '{32'h44556677, 32'hA5A5A5A5, 32'h44556677};
    vec[2] = '{32'h8899AABB, 32'hA5A5A5A5, 32'h8899AABB};
    vec[3] = '{32'hCCDDEEFF, 32'hA5A5A5A5, 32'hCCDDEEFF};
    vec[4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vec[5] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vec[6] = '{32'h0F0F0F0F, 32'h12345678, 32'h0F0F0F0F};
    vec[7] = '{32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};

    rst_n = 1'b0;
    v2 = 1'b0; data2 = '0; ordy2 = 1'b1;
    v4 = 1'b0; data4 = '0; ordy4 = 1'b1;

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready d2", rdy2, 0);
    check("rst out_valid d2", ov2, 0);
    check("rst out_data d2", od2, 0);
    check("rst in_ready d4", rdy4, 0);
    check("rst out_valid d4", ov4, 0);
    check("rst out_data d4", od4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release in_ready d2", rdy2, 1);
    check("release in_ready d4", rdy4, 1);
    @(posedge clk); #1;

    // Table-driven d=2 blocks with exact per-cycle timing and scrub probes.
    for (int i = 0; i < 8; i++) begin
      send2(vec[i].m, vec[i].r);
      @(negedge clk);
      check("tbl fold in_ready", rdy2, 0);
      @(negedge clk);
      check("tbl sh_reg zeroed", dut2.sh_reg_q, 0);
      check("tbl acc zeroed", dut2.acc_q, 0);
      if (i % 4 != 3) begin
        check("tbl in_ready back", rdy2, 1);
        check("tbl out_valid low", ov2, 0);
      end else begin
        check("tbl out_valid", ov2, 1);
        check("tbl in_ready in out", rdy2, 0);
        check("tbl out_data", od2, {vec[i-3].exp_word, vec[i-2].exp_word,
                                    vec[i-1].exp_word, vec[i].exp_word});
      end
      @(posedge clk); #1;
      if (i % 4 == 3) begin
        @(negedge clk);
        check("tbl post-out out_valid", ov2, 0);
        check("tbl post-out in_ready", rdy2, 1);
        @(posedge clk); #1;
      end
    end

    // d=4: in_valid held high, random three-share masks, reference block.
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 4; j++) begin
        mw[j] = $urandom;
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
        w4[j] = pack4(mw[j] ^ r1 ^ r2 ^ r3, r1, r2, r3);
      end
      cyc = 0; k = 0;
      v4 = 1'b1; data4 = w4[0];
      while (k < 4 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (rdy4) begin
          acc_cyc[k] = cyc;
          @(posedge clk); #1;
          k++;
          if (k < 4) data4 = w4[k];
          else v4 = 1'b0;
        end
      end
      v4 = 1'b0;
      check("d4 words accepted", k, 4);
      for (int j = 1; j < 4; j++) check("d4 accept interval", acc_cyc[j] - acc_cyc[j-1], 4);
      n = 0;
      @(negedge clk);
      while (!ov4 && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("d4 block latency", n + 1, 4);
      check("d4 out_data", od4, {mw[0], mw[1], mw[2], mw[3]});
      @(posedge clk); #1;
    end

    // Backpressure: OUT held 10 cycles with a word waiting upstream.
    ordy2 = 1'b0;
    ref_q.delete();
    for (int j = 0; j < 4; j++) begin
      m = $urandom; r1 = $urandom;
      ref_q.push_back(m);
      send2(m, r1);
    end
    n = 0;
    @(negedge clk);
    while (!ov2 && n < 50) begin
      n++;
      @(negedge clk);
    end
    m = $urandom; r1 = $urandom;
    v2 = 1'b1; data2 = pack2(m, r1);
    for (int j = 0; j < 10; j++) begin
      check("bp out_valid held", ov2, 1);
      check("bp out_data held", od2, ref_block());
      check("bp in_ready low", rdy2, 0);
      @(negedge clk);
    end
    ordy2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp in_ready after accept", rdy2, 1);
    check("bp out_valid dropped", ov2, 0);
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);
    check("bp held word taken", rdy2, 0);
    @(posedge clk); #1;
    ref_q.delete();
    ref_q.push_back(m);
    for (int j = 0; j < 3; j++) begin
      m = $urandom; r1 = $urandom;
      ref_q.push_back(m);
      send2(m, r1);
    end
    expect_blk2("bp next block", ref_block());

    // Reset after word 2 of a block, then a fresh block.
    for (int j = 0; j < 3; j++) send2($urandom, $urandom);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst sh_reg cleared", dut2.sh_reg_q, 0);
    check("midrst acc cleared", dut2.acc_q, 0);
    check("midrst buf cleared", dut2.buf_q[0], 0);
    check("midrst in_ready", rdy2, 1);
    @(posedge clk); #1;
    ref_q.delete();
    for (int j = 0; j < 4; j++) begin
      m = $urandom; r1 = $urandom;
      ref_q.push_back(m);
      send2(m, r1);
    end
    expect_blk2("midrst fresh block", ref_block());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
